// File: rtl/sdp_rdma_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdp_rdma_pkg : shared types and constants for the SDP RDMA read path
// Rev 1.0
// ---------------------------------------------------------------------------
package sdp_rdma_pkg;

  localparam int SDP_DMA_DW  = 256;
  localparam int SDP_RDMA_OW = 512;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } sdp_rdma_state_t;

  typedef struct packed {
    logic                   end_flag;
    logic [SDP_RDMA_OW-1:0] data;
  } sdp_rdma_word_t;

  // Lane index width; a single-lane word still needs a 1-bit index.
  function automatic int lane_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_rdma_sat_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdp_rdma_sat_cnt : 32-bit saturating event counter with synchronous clear
// Rev 1.0
// ---------------------------------------------------------------------------
module sdp_rdma_sat_cnt (
  input  logic        autosa_core_clk,
  input  logic        autosa_core_rstn,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != 32'hFFFF_FFFF)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/sdp_rdma_gather.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdp_rdma_gather : packs DMA response beats into {end, data} output words
// Optional stall counter under SDP_RDMA_GATHER_PERF_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module sdp_rdma_gather
  import sdp_rdma_pkg::*;
#(
  parameter int DW   = SDP_DMA_DW,
  parameter int OW   = SDP_RDMA_OW,
  parameter int CNTW = 14
) (
  input  logic            autosa_core_clk,
  input  logic            autosa_core_rstn,
  input  logic            op_en,
  input  logic [CNTW-1:0] cfg_beat_num,
  input  logic            dma_rsp_pvld,
  output logic            dma_rsp_prdy,
  input  logic [DW-1:0]   dma_rsp_pd,
  output logic            out_pvld,
  input  logic            out_prdy,
  output logic [OW:0]     out_data,
  output logic            op_done,
  output logic [31:0]     perf_stall_cnt
);

  localparam int RATIO = OW / DW;
  localparam int LW    = lane_width(RATIO);
  localparam logic [LW-1:0] c_last_lane = LW'(RATIO - 1);

  sdp_rdma_state_t r_state;
  logic [CNTW-1:0] r_beat_num;
  logic [CNTW-1:0] r_beat_cnt;
  logic [LW-1:0]   r_lane;
  logic [OW-1:0]   r_asm;
  logic            r_out_pvld;
  logic [OW:0]     r_out_data;

  logic            w_start;
  logic            w_beat_acc;
  logic            w_out_acc;
  logic            w_final;
  logic            w_word_done;
  logic [OW-1:0]   w_next_asm;

  assign w_start      = (r_state == ST_IDLE) && op_en;
  assign dma_rsp_prdy = (r_state == ST_RUN) && (!r_out_pvld || out_prdy);
  assign w_beat_acc   = dma_rsp_pvld && dma_rsp_prdy;
  assign w_out_acc    = r_out_pvld && out_prdy;
  assign w_final      = (r_beat_cnt == r_beat_num);
  assign w_word_done  = w_beat_acc && ((r_lane == c_last_lane) || w_final);

  // Lane 0 starts a fresh word, so upper lanes of a short word read as zero.
  always_comb begin
    w_next_asm = (r_lane == '0) ? '0 : r_asm;
    for (int i = 0; i < RATIO; i++) begin
      if (r_lane == LW'(i)) begin
        w_next_asm[i*DW +: DW] = dma_rsp_pd;
      end
    end
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      r_state    <= ST_IDLE;
      r_beat_num <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_en) begin
            r_beat_num <= cfg_beat_num;
            r_beat_cnt <= '0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_beat_acc) begin
            if (w_final) begin
              r_state <= ST_LAST;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        ST_LAST: begin
          if (w_out_acc) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      r_lane     <= '0;
      r_asm      <= '0;
      r_out_pvld <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_start) begin
        r_lane <= '0;
      end else if (w_beat_acc) begin
        if (w_word_done) begin
          r_lane     <= '0;
          r_out_data <= {w_final, w_next_asm};
        end else begin
          r_lane <= r_lane + 1'b1;
          r_asm  <= w_next_asm;
        end
      end

      if (w_word_done) begin
        r_out_pvld <= 1'b1;
      end else if (w_out_acc) begin
        r_out_pvld <= 1'b0;
      end
    end
  end

  assign out_pvld = r_out_pvld;
  assign out_data = r_out_data;
  assign op_done  = (r_state == ST_LAST) && w_out_acc;

`ifdef SDP_RDMA_GATHER_PERF_EN
  sdp_rdma_sat_cnt u_stall_cnt (
    .autosa_core_clk  (autosa_core_clk),
    .autosa_core_rstn (autosa_core_rstn),
    .clr              (w_start),
    .inc              (r_out_pvld && !out_prdy),
    .cnt              (perf_stall_cnt)
  );
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
`default_nettype wire
